// File: rtl/display_pkg.sv
// Shared types and constants for the display scan controller.
package display_pkg;

    // Width of one digit code presented to the shared decoder.
    localparam int DIGIT_W = 4;

    // Common-anode drivers: a high enable switches the digit off.
    localparam logic ANODE_OFF = 1'b1;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GAP   = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Larger of two integers, used when sizing the shared prescaler.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Loadable down-counter that times both the dead-time gap and the drive slot.
// The terminal flag is high while the count sits at zero.
module scan_prescaler #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    // Load a new interval or count down toward zero, then hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes one seven-segment decoder across NUM_DIGITS common-anode
// digits with frame-aligned value commit, dead-time, zero blanking and blink.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2,
    parameter int BLINK_DIV   = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digitsIn,
    input  logic                          errorIn,
    input  logic                          blankZeros,
    output logic [DIGIT_W-1:0]            binaryNumber,
    output logic                          isError,
    output logic [NUM_DIGITS-1:0]         digitEnable,
    output logic                          frameDone
);

    localparam int PRESC_MAX = max_int(REFRESH_DIV, DEAD_CYCLES);
    localparam int PRESC_W   = ($clog2(PRESC_MAX) < 1) ? 1 : $clog2(PRESC_MAX);
    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int BLINK_W   = ($clog2(BLINK_DIV) < 1) ? 1 : $clog2(BLINK_DIV);

    localparam logic [PRESC_W-1:0] DEAD_VAL   = PRESC_W'(DEAD_CYCLES - 1);
    localparam logic [PRESC_W-1:0] DRIVE_VAL  = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    scan_state_t                   state, state_next;
    logic [DIGIT_W*NUM_DIGITS-1:0] active_buf, active_next, pending_buf;
    logic                          pending_valid;
    logic [IDX_W-1:0]              scan_index, index_next;
    logic                          blink_phase;
    logic [BLINK_W-1:0]            blink_count;
    logic                          presc_load, presc_tc;
    logic [PRESC_W-1:0]            presc_value;
    logic                          enter_gap, wrap;
    logic [DIGIT_W-1:0]            next_code;
    logic [NUM_DIGITS-1:0]         tail_zero;
    logic                          running_zero;
    logic                          suppress;

    scan_prescaler #(.WIDTH(PRESC_W)) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .load     (presc_load),
        .value    (presc_value),
        .terminal (presc_tc)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= OFF;
        end else begin
            state <= state_next;
        end
    end

    // Next state, prescaler reload and slot advance; wrap marks the end of a frame.
    always_comb begin
        state_next  = state;
        presc_load  = 1'b0;
        presc_value = '0;
        enter_gap   = 1'b0;
        wrap        = 1'b0;
        index_next  = scan_index;
        case (state)
            OFF: begin
                if (load || errorIn) begin
                    state_next  = GAP;
                    enter_gap   = 1'b1;
                    index_next  = '0;
                    presc_load  = 1'b1;
                    presc_value = DEAD_VAL;
                end
            end
            GAP: begin
                if (presc_tc) begin
                    state_next  = DRIVE;
                    presc_load  = 1'b1;
                    presc_value = DRIVE_VAL;
                end
            end
            DRIVE: begin
                if (presc_tc) begin
                    state_next  = GAP;
                    enter_gap   = 1'b1;
                    presc_load  = 1'b1;
                    presc_value = DEAD_VAL;
                    if (scan_index == LAST_IDX) begin
                        wrap       = 1'b1;
                        index_next = '0;
                    end else begin
                        index_next = scan_index + 1'b1;
                    end
                end
            end
            default: state_next = OFF;
        endcase
    end

    // Active buffer only changes while idle or on the frame wrap edge; a fresh load beats a pending one.
    always_comb begin
        active_next = active_buf;
        if (state == OFF && load) begin
            active_next = digitsIn;
        end else if (wrap) begin
            if (load) begin
                active_next = digitsIn;
            end else if (pending_valid) begin
                active_next = pending_buf;
            end
        end
    end

    // Select the digit code for the slot being entered.
    always_comb begin
        next_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_next == IDX_W'(i)) begin
                next_code = active_next[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // Datapath: buffers, scan index, decoder code, error flag, blink timing, frame pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_buf    <= '0;
            pending_buf   <= '0;
            pending_valid <= 1'b0;
            scan_index    <= '0;
            binaryNumber  <= '0;
            isError       <= 1'b0;
            blink_phase   <= 1'b0;
            blink_count   <= '0;
            frameDone     <= 1'b0;
        end else begin
            active_buf <= active_next;
            scan_index <= index_next;
            isError    <= errorIn;
            frameDone  <= wrap;

            if (enter_gap) begin
                binaryNumber <= next_code;
            end

            if (wrap) begin
                pending_valid <= 1'b0;
            end else if (load && state != OFF) begin
                pending_buf   <= digitsIn;
                pending_valid <= 1'b1;
            end

            if (isError && !errorIn) begin
                blink_phase <= 1'b0;
                blink_count <= '0;
            end else if (wrap) begin
                if (blink_count == BLINK_LAST) begin
                    blink_count <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_count <= blink_count + 1'b1;
                end
            end
        end
    end

    // tail_zero[i] is set when digits i..NUM_DIGITS-1 of the active value are all zero.
    always_comb begin
        tail_zero    = '0;
        running_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            running_zero = running_zero && (active_buf[i*DIGIT_W +: DIGIT_W] == '0);
            tail_zero[i] = running_zero;
        end
    end

    // Anode drive: only the current digit during DRIVE, unless blanked or in the dark blink phase.
    always_comb begin
        digitEnable = {NUM_DIGITS{ANODE_OFF}};
        suppress    = (blankZeros && (scan_index != '0) && tail_zero[scan_index]) ||
                      (isError && blink_phase);
        if (state == DRIVE && !suppress) begin
            digitEnable[scan_index] = ~ANODE_OFF;
        end
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexes one shared sevenSegmentDisplay decoder across NUM_DIGITS common-anode digits of the vending machine front panel.
- Double-buffers the displayed value and commits it only at frame boundaries, so no digit ever tears.
- Provides dead-time between digits, leading-zero blanking and error blinking.
- Sits between the vending FSM (credit/price value, error flag) and the decoder/anode drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
REFRESH_DIV, 50000, clock cycles each digit is driven per scan slot (>=1)
DEAD_CYCLES, 2, cycles all anodes are off before each digit slot (>=1)
BLINK_DIV, 32, completed frames per error-blink phase toggle (>=1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
load  in  1  one-cycle strobe: capture digitsIn into pending buffer
digitsIn  in  4*NUM_DIGITS  packed digit codes, [3:0] = digit 0 (least significant)
errorIn  in  1  level; machine error condition
blankZeros  in  1  level; enable leading-zero blanking
binaryNumber  out  4  code to shared decoder
isError  out  1  error select to shared decoder
digitEnable  out  NUM_DIGITS  active-low anode enables, bit i = digit i
frameDone  out  1  one-cycle pulse when a full scan completes

Behaviour:
- One clock; reset is synchronous and active-high, on port reset, sampled on rising edge of clock.
- Reset values:
  - binaryNumber=0, isError=0, digitEnable=all 1 (all off), frameDone=0.
  - Active and pending buffers = 0, pendingValid=0, scanIndex=0, prescaler=0, blinkPhase=0, blinkCount=0, state=OFF.
- States:
  - OFF: enables all off; leave to GAP (scanIndex=0) on first edge with load=1 or errorIn=1. A load in OFF commits directly to active.
  - GAP: DEAD_CYCLES cycles, enables all off. binaryNumber = active digit[scanIndex], registered at GAP entry. Then go to DRIVE.
  - DRIVE: REFRESH_DIV cycles; digitEnable[scanIndex]=0 unless suppressed. At last cycle go to GAP with scanIndex+1 mod NUM_DIGITS.
- Suppression in DRIVE, enable stays 1 if either:
  - (a) blankZeros=1, scanIndex>0, and all active digits scanIndex..NUM_DIGITS-1 are 0; or
  - (b) isError=1 and blinkPhase=1.
  - Digit 0 is never zero-blanked.
- Frame wrap (DRIVE last cycle with scanIndex=NUM_DIGITS-1):
  - frameDone=1 on the next cycle only.
  - If pendingValid, active<=pending and pendingValid<=0.
  - blinkCount++; when blinkCount reaches BLINK_DIV-1 it wraps to 0 and blinkPhase toggles.
- Load:
  - Any edge with load=1 writes pending and sets pendingValid; a later load overwrites it (last wins).
  - Load on the wrap edge itself commits digitsIn directly to active.
  - Latency: new value visible from the next frame's digit-0 GAP.
- isError:
  - isError <= errorIn, registered every cycle, independent of frame.
  - When errorIn falls: blinkPhase and blinkCount reset to 0 on that edge.
- Codes 10-15 pass unchanged to binaryNumber.
- No return to OFF except by reset. Reset mid-frame aborts the scan immediately; the first post-reset cycle shows reset values.
- Prescaler width = clog2(max(REFRESH_DIV, DEAD_CYCLES)).

Decomposition:
- Shared package display_pkg: state enum (OFF, GAP, DRIVE), DIGIT_W=4, ANODE_OFF=1'b1.
- Sub-module scan_prescaler: loadable down-counter with terminal-count pulse, reused by GAP and DRIVE.
- Blanking mask logic stays in the top module as combinational logic.

Test Plan:
Common parameters: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_DIV=2. One frame = 20 cycles.
- Reset then idle: digitEnable=4'b1111, binaryNumber=0, frameDone=0 for 50 cycles.
- load with digitsIn=16'h1234, blankZeros=0:
  - Required slots: GAP 1 cycle (1111), then 4 cycles of 1110 with binaryNumber=4, then 1101/3, 1011/2, 0111/1.
  - frameDone pulses every 20 cycles.
- Mid-frame load of 16'h0056 at scanIndex=1:
  - Current frame continues showing 1234.
  - Next frame shows 6,5 and, with blankZeros=1, digits 2 and 3 enables stay 1 during DRIVE.
- Value 16'h0000 with blankZeros=1: only digit 0 lights, showing 0.
- errorIn=1: isError=1 one cycle later. Enables light for 2 frames, stay dark for 2 frames, repeating. errorIn=0 restores normal display with blinkPhase=0.
- Assert reset during digit 2 DRIVE: next cycle all enables 1, state OFF; display resumes only after a new load.
